alu_instr_decoder: RTL and testbench

Front end of the execute stage: accepts raw 32-bit instruction words over a valid/ready stream and produces the registered control bundle the ALU consumes (OpCode, HardCode, ImmdEnable, Branch, Immd, LdEnable, RdEnable, AddrEnable, NOP) plus register addresses. It assembles two-word immediate instructions, inserts a one-cycle bubble on load-use hazards, and discards in-flight work on a branch flush. It sits between instruction fetch and the register-file read / ALU.

---
 rtl/alu_instr_decoder.sv | 179 +++++++++++++++++
 tb/tb_alu_instr_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_decoder.sv
// Instruction decoder front end: one/two-word instructions -> registered ALU control bundle, 1-cycle latency.
// Backpressure: InReady drops while the output is held (OutValid && !OutReady), during a load-use stall, and on Flush.
module alu_instr_decoder (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] InWord,
    input  logic        InValid,
    output logic        InReady,
    input  logic        Flush,
    input  logic        OutReady,
    output logic        OutValid,
    output logic [1:0]  OpCode,
    output logic [1:0]  HardCode,
    output logic [2:0]  Branch,
    output logic [19:0] Immd,
    output logic        ImmdEnable,
    output logic        LdEnable,
    output logic        RdEnable,
    output logic        AddrEnable,
    output logic        NOP,
    output logic [4:0]  RsAddr,
    output logic [4:0]  RtAddr,
    output logic [4:0]  RdAddr
);

    typedef enum logic [1:0] {FETCH0, FETCH_IMM, STALL} state_t;

    typedef struct packed {
        logic [2:0]  branch;
        logic [1:0]  opcode;
        logic [1:0]  hardcode;
        logic        immd_en;
        logic        ld_en;
        logic        addr_en;
        logic        rd_en;
        logic [19:0] immd;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        nop;
    } bundle_t;

    // hdr keeps only the meaningful word0 bits: {word[31:21], word[14:0]}
    function automatic bundle_t decode(input logic [25:0] hdr, input logic [19:0] imm,
                                       input logic is_nop);
        bundle_t b;
        b.branch   = hdr[25:23];
        b.opcode   = hdr[22:21];
        b.hardcode = hdr[20:19];
        b.immd_en  = hdr[18];
        b.ld_en    = hdr[17];
        b.addr_en  = hdr[16];
        b.rd_en    = hdr[15];
        b.immd     = hdr[18] ? imm : 20'h0;
        b.rd       = hdr[14:10];
        b.rs       = hdr[9:5];
        b.rt       = hdr[4:0];
        b.nop      = is_nop;
        return b;
    endfunction

    state_t      state_q, state_d;
    logic [25:0] word0_q, word0_d;
    bundle_t     out_q, out_d;
    bundle_t     pend_q, pend_d;
    logic        out_vld_q, out_vld_d;
    logic        last_ld_vld_q, last_ld_vld_d;
    logic [4:0]  last_ld_rd_q, last_ld_rd_d;

    logic        out_free, accept, complete, hazard;
    logic [25:0] in_hdr, cur_hdr;
    logic [19:0] cur_imm;
    bundle_t     cur, bubble;

    always_comb begin
        out_free = !out_vld_q || OutReady;
        InReady  = !Flush && (state_q != STALL) && out_free;
        accept   = InValid && InReady;
        in_hdr   = {InWord[31:21], InWord[14:0]};
        cur_hdr  = (state_q == FETCH_IMM) ? word0_q : in_hdr;
        cur_imm  = (state_q == FETCH_IMM) ? InWord[19:0] : 20'h0;
        cur      = decode(cur_hdr, cur_imm, (state_q == FETCH0) && (InWord == 32'h0));
        complete = accept && ((state_q == FETCH_IMM) || !InWord[24]);
        // Rt is not a source operand when the second word carries an immediate
        hazard   = last_ld_vld_q &&
                   ((cur.rs == last_ld_rd_q) || (!cur.immd_en && (cur.rt == last_ld_rd_q)));
        bubble     = '0;
        bubble.nop = 1'b1;

        state_d       = state_q;
        word0_d       = word0_q;
        out_d         = out_q;
        pend_d        = pend_q;
        out_vld_d     = out_vld_q;
        last_ld_vld_d = last_ld_vld_q;
        last_ld_rd_d  = last_ld_rd_q;

        if (Flush) begin
            out_vld_d     = 1'b0;
            state_d       = FETCH0;
            last_ld_vld_d = 1'b0;
        end else begin
            if (out_vld_q && OutReady) begin
                out_vld_d = 1'b0;
            end
            case (state_q)
                FETCH0: begin
                    if (accept && InWord[24]) begin
                        word0_d = in_hdr;
                        state_d = FETCH_IMM;
                    end
                end
                FETCH_IMM: begin
                    if (accept) begin
                        state_d = FETCH0;
                    end
                end
                STALL: begin
                    if (out_vld_q && OutReady) begin
                        out_d         = pend_q;
                        out_vld_d     = 1'b1;
                        last_ld_vld_d = pend_q.ld_en;
                        last_ld_rd_d  = pend_q.rd;
                        state_d       = FETCH0;
                    end
                end
                default: state_d = FETCH0;
            endcase
            if (complete) begin
                out_vld_d = 1'b1;
                if (hazard) begin
                    out_d         = bubble;
                    pend_d        = cur;
                    state_d       = STALL;
                    last_ld_vld_d = 1'b0;
                end else begin
                    out_d         = cur;
                    last_ld_vld_d = cur.ld_en;
                    last_ld_rd_d  = cur.rd;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= FETCH0;
            word0_q       <= '0;
            out_q         <= '0;
            pend_q        <= '0;
            out_vld_q     <= 1'b0;
            last_ld_vld_q <= 1'b0;
            last_ld_rd_q  <= '0;
        end else begin
            state_q       <= state_d;
            word0_q       <= word0_d;
            out_q         <= out_d;
            pend_q        <= pend_d;
            out_vld_q     <= out_vld_d;
            last_ld_vld_q <= last_ld_vld_d;
            last_ld_rd_q  <= last_ld_rd_d;
        end
    end

    assign OutValid   = out_vld_q;
    assign Branch     = out_q.branch;
    assign OpCode     = out_q.opcode;
    assign HardCode   = out_q.hardcode;
    assign ImmdEnable = out_q.immd_en;
    assign LdEnable   = out_q.ld_en;
    assign AddrEnable = out_q.addr_en;
    assign RdEnable   = out_q.rd_en;
    assign Immd       = out_q.immd;
    assign RdAddr     = out_q.rd;
    assign RsAddr     = out_q.rs;
    assign RtAddr     = out_q.rt;
    assign NOP        = out_q.nop;

endmodule

// File: tb/tb_alu_instr_decoder.sv
// Scoreboard bench for alu_instr_decoder: expected bundles queued at stimulus time, popped when taken.
module tb_alu_instr_decoder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] InWord;
    logic        InValid;
    logic        InReady;
    logic        Flush;
    logic        OutReady;
    logic        OutValid;
    logic [1:0]  OpCode;
    logic [1:0]  HardCode;
    logic [2:0]  Branch;
    logic [19:0] Immd;
    logic        ImmdEnable, LdEnable, RdEnable, AddrEnable, NOP;
    logic [4:0]  RsAddr, RtAddr, RdAddr;

    alu_instr_decoder dut (
        .Clk(Clk), .Reset(Reset), .InWord(InWord), .InValid(InValid), .InReady(InReady),
        .Flush(Flush), .OutReady(OutReady), .OutValid(OutValid), .OpCode(OpCode),
        .HardCode(HardCode), .Branch(Branch), .Immd(Immd), .ImmdEnable(ImmdEnable),
        .LdEnable(LdEnable), .RdEnable(RdEnable), .AddrEnable(AddrEnable), .NOP(NOP),
        .RsAddr(RsAddr), .RtAddr(RtAddr), .RdAddr(RdAddr)
    );

    always #5 Clk = ~Clk;

    typedef logic [46:0] bvec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    bvec_t exp_q[$];
    bvec_t obs;

    localparam bvec_t BUBBLE = 47'd1;
    localparam logic [31:0] LD5 = 32'h0080_1400;
    localparam logic [31:0] A5  = 32'h0800_20A7;
    localparam logic [31:0] A6  = 32'h0800_20C7;
    localparam logic [31:0] I6  = 32'h0100_20C5;
    localparam logic [31:0] R5  = 32'h0800_20C5;

    assign obs = {Branch, OpCode, HardCode, ImmdEnable, LdEnable, AddrEnable, RdEnable,
                  Immd, RdAddr, RsAddr, RtAddr, NOP};

    always @(posedge Clk) cyc++;

    function automatic bvec_t dec(input logic [31:0] w0, input logic [31:0] w1);
        return {w0[31:29], w0[28:27], w0[26:25], w0[24], w0[23], w0[22], w0[21],
                (w0[24] ? w1[19:0] : 20'h0), w0[14:10], w0[9:5], w0[4:0], (w0 == 32'h0)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        int t = 0;
        InWord  = w;
        InValid = 1'b1;
        @(negedge Clk);
        while (!InReady && t < 50) begin
            @(negedge Clk);
            t++;
        end
        if (!InReady) check("send_timeout", InReady, 1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        InWord  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (!Reset && !Flush && OutValid && OutReady) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", OutValid, 0);
            end else begin
                check("sb_bundle", obs, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; InValid = 1'b0; InWord = '0; Flush = 1'b0; OutReady = 1'b1;
        idle(2);
        check("rst_outvalid", OutValid, 0);
        check("rst_bundle", obs, 0);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_inready", InReady, 1);
        idle(1);

        // single-word instruction
        exp_q.push_back(dec(32'h0800_0443, 0));
        send(32'h0800_0443);
        check("t1_vld", OutValid, 1);
        check("t1_op", OpCode, 1);
        check("t1_rd", RdAddr, 1);
        check("t1_rs", RsAddr, 2);
        check("t1_rt", RtAddr, 3);
        check("t1_immd", Immd, 0);
        check("t1_nop", NOP, 0);

        // two-word immediate with 3 idle cycles between the words
        send(32'h0100_0420);
        repeat (3) begin
            @(negedge Clk);
            check("t2_gap_idle", OutValid, 0);
        end
        idle(1);
        exp_q.push_back(dec(32'h0100_0420, 32'hFFF1_2345));
        send(32'hFFF1_2345);
        check("t2_vld", OutValid, 1);
        check("t2_immd", Immd, 20'h12345);
        check("t2_ie", ImmdEnable, 1);
        check("t2_rs", RsAddr, 1);

        // load-use on Rs: bubble then the add
        exp_q.push_back(dec(LD5, 0));
        exp_q.push_back(BUBBLE);
        exp_q.push_back(dec(A5, 0));
        send(LD5);
        send(A5);
        check("t3_bubble_vld", OutValid, 1);
        check("t3_bubble_nop", NOP, 1);
        check("t3_bubble_fields", obs, BUBBLE);
        check("t3_stall_inready", InReady, 0);
        idle(1);
        check("t3_after_bubble", obs, dec(A5, 0));

        // no dependency: no bubble
        exp_q.push_back(dec(LD5, 0));
        exp_q.push_back(dec(A6, 0));
        send(LD5);
        send(A6);
        check("t3_nohaz_rs6", obs, dec(A6, 0));

        // Rt matches but the instruction carries an immediate: no bubble
        exp_q.push_back(dec(LD5, 0));
        exp_q.push_back(dec(I6, 32'h0000_0ABC));
        send(LD5);
        send(I6);
        send(32'h0000_0ABC);
        check("t3_imm_rt_nohaz", obs, dec(I6, 32'h0000_0ABC));

        // Rt match without immediate: bubble
        exp_q.push_back(dec(LD5, 0));
        exp_q.push_back(BUBBLE);
        exp_q.push_back(dec(R5, 0));
        send(LD5);
        send(R5);
        check("t3_rt_haz_nop", NOP, 1);
        idle(2);

        // backpressure hold, then back-to-back issue
        OutReady = 1'b0;
        exp_q.push_back(dec(32'h2A00_1C61, 0));
        send(32'h2A00_1C61);
        InWord  = 32'h4E00_2D4A;
        InValid = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            check("t4_hold_bundle", obs, dec(32'h2A00_1C61, 0));
            check("t4_hold_vld", OutValid, 1);
            check("t4_hold_inready", InReady, 0);
        end
        idle(1);
        OutReady = 1'b1;
        exp_q.push_back(dec(32'h4E00_2D4A, 0));
        exp_q.push_back(dec(32'h9600_0421, 0));
        exp_q.push_back(dec(32'h0000_7FFF, 0));
        begin
            int t0;
            t0 = cyc;
            send(32'h4E00_2D4A);
            send(32'h9600_0421);
            send(32'h0000_7FFF);
            check("t4_b2b_cycles", cyc - t0, 3);
        end
        idle(2);

        // flush while waiting for the immediate word
        send(32'h0100_0420);
        Flush   = 1'b1;
        InValid = 1'b1;
        InWord  = 32'h0000_0777;
        @(negedge Clk);
        check("t5_flush_inready", InReady, 0);
        idle(1);
        Flush   = 1'b0;
        InValid = 1'b0;
        check("t5_flush_vld", OutValid, 0);
        exp_q.push_back(dec(32'h0800_0443, 0));
        send(32'h0800_0443);
        check("t5_word0_after_flush", obs, dec(32'h0800_0443, 0));
        idle(2);

        // flush during a load-use stall
        exp_q.push_back(dec(LD5, 0));
        send(LD5);
        send(A5);
        OutReady = 1'b0;
        @(negedge Clk);
        check("t6_stall_bubble", obs, BUBBLE);
        check("t6_stall_inready", InReady, 0);
        idle(1);
        Flush = 1'b1;
        idle(1);
        Flush = 1'b0;
        check("t6_flush_vld", OutValid, 0);
        OutReady = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            check("t6_no_pending", OutValid, 0);
        end
        idle(1);
        exp_q.push_back(dec(A5, 0));
        send(A5);
        check("t6_no_haz_after_flush", obs, dec(A5, 0));
        idle(2);

        // reset during a load-use stall
        exp_q.push_back(dec(LD5, 0));
        send(LD5);
        send(A5);
        OutReady = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check("t7_rst_vld", OutValid, 0);
        check("t7_rst_bundle", obs, 0);
        idle(1);
        Reset    = 1'b0;
        OutReady = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            check("t7_no_pending", OutValid, 0);
        end
        idle(1);
        exp_q.push_back(dec(A5, 0));
        send(A5);
        check("t7_post_rst", obs, dec(A5, 0));
        idle(2);

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
